// File: rtl/matrix_commutator_fsm.sv
// rtl/matrix_commutator_fsm.sv - four-step current-sign commutation sequencer for one matrix-converter output leg
//
// Drives the forward/reverse gate pair of every input-phase bidirectional
// switch so that moving the load from one source phase to another never
// shorts two sources and never opens the inductive load path.
//
// Parameters:
//   NPH          number of input phases (>= 2)
//   STEP_CYCLES  clock cycles each intermediate step is held (>= 1)
//   SW           select width, derived from NPH (do not override)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   DesiredLoad  requested source phase, 0 = no request, 1..NPH = phase
//   CurrentSign  load current sign, 1 = source->load (forward device)
//   Sout         gate drives; phase p: forward Sout[2(NPH-p)+1],
//                reverse Sout[2(NPH-p)]; phase 1 is the MSB pair
//   busy         high while an intermediate step is being held
//   done         one-cycle pulse when a commutation completes
//   illegal      one-cycle pulse when a select > NPH is sampled in OFF/ON
//
// Optional feature macro: COMM_SIGN_FILTER_EN
//   defined   : CurrentSign is passed through a 2-flop synchronizer and
//               the synchronized value is latched at commutation start
//   undefined : the raw CurrentSign is latched

module matrix_commutator_fsm #(
    parameter int NPH         = 3,
    parameter int STEP_CYCLES = 4,
    parameter int SW          = $clog2(NPH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW-1:0]     DesiredLoad,
    input  logic              CurrentSign,
    output logic [2*NPH-1:0]  Sout,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_RELOAD = DW'(STEP_CYCLES - 1);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_ON    = 3'd1;
    localparam logic [2:0] ST_STEP1 = 3'd2;
    localparam logic [2:0] ST_STEP2 = 3'd3;
    localparam logic [2:0] ST_STEP3 = 3'd4;

    logic [2:0]    state, n_state;
    logic [SW-1:0] cur, n_cur;
    logic [SW-1:0] tgt, n_tgt;
    logic          sgn, n_sgn;
    logic [DW-1:0] dwell, n_dwell;
    logic          n_done;
    logic          n_illegal;
    logic          n_busy;
    logic [2*NPH-1:0] n_sout;

    logic          sign_use;
    logic [31:0]   sel_wide;
    logic          sel_valid;
    logic          sel_over;

    // Sign source selection: optional metastability filter on the
    // asynchronous current-sign comparator output.
`ifdef COMM_SIGN_FILTER_EN
    logic sign_meta;
    logic sign_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_meta <= 1'b0;
            sign_sync <= 1'b0;
        end else begin
            sign_meta <= CurrentSign;
            sign_sync <= sign_meta;
        end
    end

    assign sign_use = sign_sync;
`else
    assign sign_use = CurrentSign;
`endif

    // Compare in a wide domain so the range check stays meaningful even
    // when NPH fills the select width exactly.
    assign sel_wide  = 32'(DesiredLoad);
    assign sel_valid = (sel_wide != 32'd0) && (sel_wide <= 32'(NPH));
    assign sel_over  = (sel_wide > 32'(NPH));

    // One-hot mask of a single device of phase ph (forward or reverse).
    // Select 0 (no source) yields an empty mask.
    function automatic logic [2*NPH-1:0] dev_mask(input logic [SW-1:0] ph,
                                                  input logic fwd);
        logic [2*NPH-1:0] m;
        m = '0;
        for (int p = 1; p <= NPH; p++) begin
            if (ph == SW'(p)) begin
                m[2*(NPH-p) + (fwd ? 1 : 0)] = 1'b1;
            end
        end
        return m;
    endfunction

    // Gate pattern for a given state. Intermediate steps only ever use the
    // device that conducts in the latched current direction, so the load
    // path is never broken and opposite-direction devices of different
    // phases are never on together.
    function automatic logic [2*NPH-1:0] gate_pattern(input logic [2:0]    st,
                                                      input logic [SW-1:0] c,
                                                      input logic [SW-1:0] t,
                                                      input logic          s);
        logic [2*NPH-1:0] g;
        case (st)
            ST_ON:    g = dev_mask(c, 1'b1) | dev_mask(c, 1'b0);
            ST_STEP1: g = dev_mask(c, s);
            ST_STEP2: g = dev_mask(c, s) | dev_mask(t, s);
            ST_STEP3: g = dev_mask(t, s);
            default:  g = '0;
        endcase
        return g;
    endfunction

    always_comb begin
        n_state   = state;
        n_cur     = cur;
        n_tgt     = tgt;
        n_sgn     = sgn;
        n_dwell   = dwell;
        n_done    = 1'b0;
        n_illegal = 1'b0;

        case (state)
            ST_OFF: begin
                if (sel_valid) begin
                    n_state = ST_ON;
                    n_cur   = DesiredLoad;
                end else if (sel_over) begin
                    n_illegal = 1'b1;
                end
            end

            ST_ON: begin
                // Select 0 deliberately holds the present source: the
                // inductive load must never be opened by the modulator.
                if (sel_valid && (DesiredLoad != cur)) begin
                    n_state = ST_STEP1;
                    n_tgt   = DesiredLoad;
                    n_sgn   = sign_use;
                    n_dwell = DWELL_RELOAD;
                end else if (sel_over) begin
                    n_illegal = 1'b1;
                end
            end

            ST_STEP1: begin
                if (dwell == '0) begin
                    n_state = ST_STEP2;
                    n_dwell = DWELL_RELOAD;
                end else begin
                    n_dwell = dwell - DW'(1);
                end
            end

            ST_STEP2: begin
                if (dwell == '0) begin
                    n_state = ST_STEP3;
                    n_dwell = DWELL_RELOAD;
                end else begin
                    n_dwell = dwell - DW'(1);
                end
            end

            ST_STEP3: begin
                if (dwell == '0) begin
                    n_state = ST_ON;
                    n_cur   = tgt;
                    n_dwell = DWELL_RELOAD;
                    n_done  = 1'b1;
                end else begin
                    n_dwell = dwell - DW'(1);
                end
            end

            default: begin
                // Unreachable encodings recover to the safe all-off state.
                n_state = ST_OFF;
                n_cur   = '0;
                n_tgt   = '0;
                n_sgn   = 1'b0;
                n_dwell = '0;
            end
        endcase

        n_busy = (n_state == ST_STEP1) || (n_state == ST_STEP2) ||
                 (n_state == ST_STEP3);
        n_sout = gate_pattern(n_state, n_cur, n_tgt, n_sgn);
    end

    // Outputs are registered from next-state values so that they change on
    // the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_OFF;
            cur     <= '0;
            tgt     <= '0;
            sgn     <= 1'b0;
            dwell   <= '0;
            Sout    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= n_state;
            cur     <= n_cur;
            tgt     <= n_tgt;
            sgn     <= n_sgn;
            dwell   <= n_dwell;
            Sout    <= n_sout;
            busy    <= n_busy;
            done    <= n_done;
            illegal <= n_illegal;
        end
    end

endmodule

// File: tb/tb_matrix_commutator_fsm.sv
// tb/tb_matrix_commutator_fsm.sv - scoreboard bench for matrix_commutator_fsm
module tb_matrix_commutator_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [1:0] dl3 = '0;
    logic       cs3 = 1'b0;
    logic [5:0] s3;
    logic       busy3, done3, ill3;

    logic [2:0] dl5 = '0;
    logic       cs5 = 1'b0;
    logic [9:0] s5;
    logic       busy5, done5, ill5;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    bit inv_en = 1'b0;

    typedef struct {
        logic [9:0] sout;
        logic       busy;
        logic       done;
        logic       illegal;
        bit         i5;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    logic [9:0] act_s;
    logic       act_b, act_d, act_i;

    matrix_commutator_fsm #(.NPH(3), .STEP_CYCLES(4)) dut3 (
        .clk(clk), .rst(rst), .DesiredLoad(dl3), .CurrentSign(cs3),
        .Sout(s3), .busy(busy3), .done(done3), .illegal(ill3)
    );

    matrix_commutator_fsm #(.NPH(5), .STEP_CYCLES(1)) dut5 (
        .clk(clk), .rst(rst), .DesiredLoad(dl5), .CurrentSign(cs5),
        .Sout(s5), .busy(busy5), .done(done5), .illegal(ill5)
    );

    always #5 clk = ~clk;

    function automatic bit inv_ok(input logic [9:0] s, input int nph);
        int cnt;
        bit ok;
        cnt = 0;
        ok  = 1'b1;
        for (int i = 0; i < 2*nph; i++) cnt += int'(s[i]);
        if (cnt > 2) ok = 1'b0;
        for (int p = 1; p <= nph; p++)
            for (int q = 1; q <= nph; q++)
                if (p != q && s[2*(nph-p)+1] && s[2*(nph-q)]) ok = 1'b0;
        return ok;
    endfunction

    // Scoreboard pop/compare plus gate-safety invariant, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act_s = e.i5 ? s5 : {4'b0000, s3};
            act_b = e.i5 ? busy5 : busy3;
            act_d = e.i5 ? done5 : done3;
            act_i = e.i5 ? ill5 : ill3;
            tests++;
            if ({act_s, act_b, act_d, act_i} !== {e.sout, e.busy, e.done, e.illegal}) begin
                failed++;
                $display("FAIL sb_nph%0d cycle %0d: got sout=%b busy=%b done=%b illegal=%b, expected sout=%b busy=%b done=%b illegal=%b",
                         e.i5 ? 5 : 3, cyc, act_s, act_b, act_d, act_i,
                         e.sout, e.busy, e.done, e.illegal);
            end
        end
        if (inv_en) begin
            tests++;
            if (!inv_ok({4'b0000, s3}, 3) || !inv_ok(s5, 5)) begin
                failed++;
                $display("FAIL invariant cycle %0d: got s3=%b s5=%b, required <=2 bits and no cross-phase opposite pair",
                         cyc, s3, s5);
            end
        end
    end

    task automatic push(input bit i5, input logic [9:0] s, input logic b,
                        input logic d, input logic il, input int n);
        exp_t x;
        x.sout = s; x.busy = b; x.done = d; x.illegal = il; x.i5 = i5;
        for (int k = 0; k < n; k++) sb_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        if (sb_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL %s timeout: got %0d pending entries, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        dl3 = '0; cs3 = 1'b0; dl5 = '0; cs5 = 1'b0;
        step(3);
        tests++;
        if ({s3, busy3, done3, ill3} !== 9'b0) begin
            failed++;
            $display("FAIL reset_nph3: got sout=%b busy=%b done=%b illegal=%b, required all 0", s3, busy3, done3, ill3);
        end
        tests++;
        if ({s5, busy5, done5, ill5} !== 13'b0) begin
            failed++;
            $display("FAIL reset_nph5: got sout=%b busy=%b done=%b illegal=%b, required all 0", s5, busy5, done5, ill5);
        end
        rst    = 1'b0;
        inv_en = 1'b1;
        step(1);
    endtask

    task automatic test_off_to_on;
        dl3 = 2'd1;
        push(0, 10'b0000110000, 0, 0, 0, 4);
        step(1);
        dl3 = 2'd0;
        drain("off_to_on");
    endtask

    task automatic test_fwd_commutation;
        dl3 = 2'd2; cs3 = 1'b1;
        push(0, 10'b0000100000, 1, 0, 0, 4);
        push(0, 10'b0000101000, 1, 0, 0, 4);
        push(0, 10'b0000001000, 1, 0, 0, 4);
        push(0, 10'b0000001100, 0, 1, 0, 1);
        push(0, 10'b0000001100, 0, 0, 0, 1);
        drain("fwd_commutation");
    endtask

    task automatic test_rev_commutation;
        dl3 = 2'd3; cs3 = 1'b0;
        push(0, 10'b0000000100, 1, 0, 0, 4);
        push(0, 10'b0000000101, 1, 0, 0, 4);
        push(0, 10'b0000000001, 1, 0, 0, 4);
        push(0, 10'b0000000011, 0, 1, 0, 1);
        push(0, 10'b0000000011, 0, 0, 0, 1);
        drain("rev_commutation");
    endtask

    task automatic test_ignore_midstep;
        dl3 = 2'd2; cs3 = 1'b1;
        push(0, 10'b0000000010, 1, 0, 0, 4);
        push(0, 10'b0000001010, 1, 0, 0, 4);
        push(0, 10'b0000001000, 1, 0, 0, 4);
        push(0, 10'b0000001100, 0, 1, 0, 1);
        push(0, 10'b0000000100, 1, 0, 0, 4);
        push(0, 10'b0000010100, 1, 0, 0, 4);
        push(0, 10'b0000010000, 1, 0, 0, 4);
        push(0, 10'b0000110000, 0, 1, 0, 1);
        push(0, 10'b0000110000, 0, 0, 0, 1);
        step(6);
        dl3 = 2'd1; cs3 = 1'b0;
        drain("ignore_midstep");
    endtask

    task automatic test_reset_mid_step3;
        dl3 = 2'd3; cs3 = 1'b1;
        push(0, 10'b0000100000, 1, 0, 0, 4);
        push(0, 10'b0000100010, 1, 0, 0, 4);
        push(0, 10'b0000000010, 1, 0, 0, 2);
        step(10);
        rst = 1'b1; dl3 = 2'd0;
        push(0, 10'b0000000000, 0, 0, 0, 1);
        step(1);
        rst = 1'b0;
        push(0, 10'b0000000000, 0, 0, 0, 1);
        drain("reset_mid_step3");
    endtask

    task automatic test_illegal;
        dl5 = 3'd6;
        push(1, 10'b0000000000, 0, 0, 1, 1);
        step(1);
        dl5 = 3'd3;
        push(1, 10'b0000110000, 0, 0, 0, 1);
        step(1);
        dl5 = 3'd7;
        push(1, 10'b0000110000, 0, 0, 1, 1);
        step(1);
        dl5 = 3'd0;
        push(1, 10'b0000110000, 0, 0, 0, 1);
        drain("illegal");
    endtask

    task automatic test_back_to_back;
        dl5 = 3'd5; cs5 = 1'b1;
        push(1, 10'b0000100000, 1, 0, 0, 1);
        push(1, 10'b0000100010, 1, 0, 0, 1);
        push(1, 10'b0000000010, 1, 0, 0, 1);
        push(1, 10'b0000000011, 0, 1, 0, 1);
        push(1, 10'b0000000001, 1, 0, 0, 1);
        push(1, 10'b0100000001, 1, 0, 0, 1);
        push(1, 10'b0100000000, 1, 0, 0, 1);
        push(1, 10'b1100000000, 0, 1, 0, 1);
        push(1, 10'b1100000000, 0, 0, 0, 1);
        step(1);
        dl5 = 3'd1; cs5 = 1'b0;
        drain("back_to_back");
    endtask

    initial begin
        step(1);
        test_reset;
        test_off_to_on;
        test_fwd_commutation;
        test_rev_commutation;
        test_ignore_midstep;
        test_reset_mid_step3;
        test_illegal;
        test_back_to_back;
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
